// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM encoding,
// register offsets, CTRL bit positions and MODE codes.
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_CNT  = 2'b10;
    localparam logic [1:0] ST_INT  = 2'b11;

    localparam logic [1:0] CTRL_OFS   = 2'b00;
    localparam logic [1:0] PRESET_OFS = 2'b01;
    localparam logic [1:0] COUNT_OFS  = 2'b10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_STAT    = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only the exact RELOAD code auto-reloads; 1x falls back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/mips_timer.sv
// 32-bit countdown timer on the CPU device bus with CTRL/PRESET/COUNT registers.
// Optional TIMER_STATUS_EN exposes the one-shot pending flag in CTRL[4].
module mips_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        irq_flag;

    logic        hit;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_update;
    logic        oneshot_done;
    logic        stat_bit;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        hit          = 1'b0;
        wr_ctrl      = 1'b0;
        wr_preset    = 1'b0;
        ctrl_update  = 1'b0;
        oneshot_done = 1'b0;
        hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
        wr_ctrl   = we && hit && (addr[3:2] == CTRL_OFS);
        wr_preset = we && hit && (addr[3:2] == PRESET_OFS);
`ifdef TIMER_STATUS_EN
        // A CTRL write with the status bit set only acknowledges the flag.
        ctrl_update = wr_ctrl && !wd[CTRL_STAT];
`else
        ctrl_update = wr_ctrl;
`endif
        oneshot_done = (state == ST_INT) && !is_reload(ctrl_mode);
    end

`ifdef TIMER_STATUS_EN
    assign stat_bit = irq_flag;
`else
    assign stat_bit = 1'b0;
`endif

    always_comb begin
        rd = '0;
        case (addr[3:2])
            CTRL_OFS:   rd = {27'd0, stat_bit, ctrl_im, ctrl_mode, ctrl_en};
            PRESET_OFS: rd = preset;
            COUNT_OFS:  rd = count;
            default:    rd = '0;
        endcase
    end

    // NOTE: sequential state is assigned with non-blocking <= so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            state     <= ST_IDLE;
            irq_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (ctrl_en) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count <= 32'd1) begin
                        count <= '0;
                        state <= ST_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                default: state <= is_reload(ctrl_mode) ? ST_LOAD : ST_IDLE;
            endcase

            // Bus write to CTRL takes priority over the one-shot EN clear.
            if (ctrl_update) begin
                ctrl_en   <= wd[CTRL_EN];
                ctrl_mode <= wd[CTRL_MODE_HI:CTRL_MODE_LO];
                ctrl_im   <= wd[CTRL_IM];
            end else if (oneshot_done) begin
                ctrl_en <= 1'b0;
            end

            if (wr_preset) preset <= wd;

            if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
            else if (oneshot_done)    irq_flag <= 1'b1;
        end
    end

    assign irq = is_reload(ctrl_mode) ? ((state == ST_INT) && ctrl_im)
                                      : (irq_flag && ctrl_im);

endmodule
